uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLOCK_COUNTER_WIDTH, default 10, giving the width of the bit-period counter.
REQ-002 The block SHALL have parameter BIT_COUNTER_WIDTH, default 3, giving the width of the data-bit index counter.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-004 The block SHALL have parameter CLOCKS_PER_BIT, default 434, giving the clock cycles per serial bit.
REQ-005 The block SHALL have port i_clock, input, 1 bit, the single clock, rising-edge active.
REQ-006 The block SHALL have port i_resetL, input, 1 bit, reset, asynchronous and active-low.
REQ-007 The block SHALL have port i_start, input, 1 bit, a transmit request sampled on the rising edge.
REQ-008 The block SHALL have port i_data, input, DATA_WIDTH bits, the payload captured on accept.
REQ-009 The block SHALL have port o_TX, output, 1 bit, the serial line with idle-high polarity.
REQ-010 The block SHALL have port o_busy, output, 1 bit, high while a frame is in flight.
REQ-011 The block SHALL have port o_done, output, 1 bit, a one-cycle pulse at frame completion.

Function
REQ-012 The state machine SHALL have the states IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only) and STOP_BIT.
REQ-013 In IDLE with i_start=1, the block SHALL latch i_data into a shift register and move to START_BIT on the same edge; o_TX SHALL go low and o_busy high in the following cycle.
REQ-014 Each bit state SHALL last exactly CLOCKS_PER_BIT cycles; the clock counter SHALL count 0..CLOCKS_PER_BIT-1 and clear on every state change.
REQ-015 DATA_BITS SHALL send the payload LSB first; the bit index SHALL count 0..DATA_WIDTH-1, and after the last bit the state SHALL go to STOP_BIT (or PARITY_BIT).
REQ-016 STOP_BIT SHALL drive o_TX=1 for CLOCKS_PER_BIT cycles and then return to IDLE.
REQ-017 On the return to IDLE, o_done SHALL be 1 for exactly one cycle and o_busy SHALL be 0 in that same cycle.
REQ-018 An i_start in the o_done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-019 i_start while o_busy=1 SHALL be ignored, and changes to i_data after accept SHALL NOT affect the frame.
REQ-020 The frame length from accept to o_done SHALL be (DATA_WIDTH+2)*CLOCKS_PER_BIT cycles, or +CLOCKS_PER_BIT with parity.
REQ-021 CLOCK_COUNTER_WIDTH SHALL satisfy 2^CLOCK_COUNTER_WIDTH > CLOCKS_PER_BIT-1, and BIT_COUNTER_WIDTH SHALL satisfy 2^BIT_COUNTER_WIDTH >= DATA_WIDTH; counter comparisons SHALL be unsigned at counter width.
REQ-022 o_TX SHALL be driven directly from a register so that the line is glitch-free.

Reset
REQ-023 While i_resetL=0: state=IDLE, o_TX=1, o_busy=0, o_done=0, and counters and shift register =0.
REQ-024 Reset asserted mid-frame SHALL force o_TX high immediately, without waiting for a clock, and abandon the frame without an o_done pulse.
REQ-025 Once i_resetL=1, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: PARITY_BIT SHALL be inserted between DATA_BITS and STOP_BIT, carrying the even-parity bit (XOR of the latched payload) for CLOCKS_PER_BIT cycles.
REQ-027 Macro UART_TX_PARITY_EN undefined: PARITY_BIT and its logic SHALL be absent, and DATA_BITS SHALL go directly to STOP_BIT.

Structure
REQ-028 The state encodings and the line levels IDLE_LEVEL=1 and START_LEVEL=0 SHALL live in the shared package uart_pkg, which is also used by the receiver.
REQ-029 The bit-period counter SHALL be a sub-module uart_baud_counter (clear input, o_bit_end pulse at count CLOCKS_PER_BIT-1); all other logic SHALL be in uart_transmitter.

Verification (CLOCKS_PER_BIT=4, DATA_WIDTH=8 unless noted)
REQ-030 i_data=8'h55 with a one-cycle i_start -> o_TX samples per bit 0,1,0,1,0,1,0,1,0,1; o_done at cycle 40 after accept.
REQ-031 i_start held high for 3 frames, data A5/3C/FF -> three contiguous 40-cycle frames with no idle gap and three o_done pulses.
REQ-032 i_start pulsed at cycle 10 of a frame with new i_data -> ignored; the frame is unchanged and there is only one o_done.
REQ-033 i_resetL dropped at cycle 17 of the 0x00 frame -> o_TX=1 asynchronously, o_busy=0, no o_done; a next frame sent after release is correct.
REQ-034 With UART_TX_PARITY_EN, i_data=8'h07 -> parity bit 1; with i_data=8'h03 -> parity bit 0; frame length 44 cycles.
REQ-035 With CLOCKS_PER_BIT=434 and CLOCK_COUNTER_WIDTH=10, loopback into the existing receiver -> the received byte equals the sent byte for all 256 values.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels and FSM state encodings (also used by the receiver).
// UART_TX_PARITY_EN adds the PARITY_BIT state encoding.
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLOCKS_PER_BIT-1, flags the last count of each bit.
module uart_baud_counter #(
  parameter int CLOCK_COUNTER_WIDTH = 10,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic i_clock,
  input  logic i_resetL,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_COUNT =
    CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);

  logic [CLOCK_COUNTER_WIDTH-1:0] count_reg;

  // Wraps at the end of each bit so consecutive bits of one state need no clear.
  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      count_reg <= '0;
    end else if (i_clear || o_bit_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign o_bit_end = (count_reg == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1-style framing, LSB first, idle-high line driven from a register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_COUNTER_WIDTH = 10,
  parameter int BIT_COUNTER_WIDTH   = 3,
  parameter int DATA_WIDTH          = 8,
  parameter int CLOCKS_PER_BIT      = 434
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_TX,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

  uart_state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]        shift_reg, shift_next;
  logic [BIT_COUNTER_WIDTH-1:0] bit_idx_reg, bit_idx_next;
  logic                         tx_reg, tx_next;
  logic                         done_reg, done_next;
  logic                         bit_end;
  logic                         count_clear;
`ifdef UART_TX_PARITY_EN
  logic                         parity_reg, parity_next;
`endif

  assign count_clear = (state_reg == IDLE) || (state_next != state_reg);

  uart_baud_counter #(
    .CLOCK_COUNTER_WIDTH(CLOCK_COUNTER_WIDTH),
    .CLOCKS_PER_BIT     (CLOCKS_PER_BIT)
  ) u_baud_counter (
    .i_clock  (i_clock),
    .i_resetL (i_resetL),
    .i_clear  (count_clear),
    .o_bit_end(bit_end)
  );

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= IDLE_LEVEL;
      done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (i_start) state_next = START_BIT;
      START_BIT: if (bit_end) state_next = DATA_BITS;
      DATA_BITS: begin
        if (bit_end && (bit_idx_reg == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY_BIT;
`else
          state_next = STOP_BIT;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: if (bit_end) state_next = STOP_BIT;
`endif
      STOP_BIT:  if (bit_end) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // The line level is computed for the state being entered, so tx_reg changes on the same edge.
  always_comb begin
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          shift_next = i_data;
`ifdef UART_TX_PARITY_EN
          parity_next = ^i_data;
`endif
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          shift_next   = shift_reg >> 1;
          bit_idx_next = (bit_idx_reg == LAST_BIT) ? '0 : bit_idx_reg + 1'b1;
        end
      end
      default: ;
    endcase

    done_next = (state_reg == STOP_BIT) && (state_next == IDLE);

    case (state_next)
      START_BIT:  tx_next = START_LEVEL;
      DATA_BITS:  tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY_BIT: tx_next = parity_next;
`endif
      default:    tx_next = IDLE_LEVEL;
    endcase
  end

  assign o_TX   = tx_reg;
  assign o_busy = (state_reg != IDLE);
  assign o_done = done_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (CLOCKS_PER_BIT=4, DATA_WIDTH=8); follows UART_TX_PARITY_EN.
module tb_uart_transmitter;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FRAME_LEN = NBITS * CPB;

  logic          i_clock  = 1'b0;
  logic          i_resetL = 1'b0;
  logic          i_start  = 1'b0;
  logic [DW-1:0] i_data   = '0;
  logic          o_TX, o_busy, o_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 i_clock = ~i_clock;

  uart_transmitter #(
    .CLOCK_COUNTER_WIDTH(10),
    .BIT_COUNTER_WIDTH  (3),
    .DATA_WIDTH         (DW),
    .CLOCKS_PER_BIT     (CPB)
  ) dut (
    .i_clock (i_clock),
    .i_resetL(i_resetL),
    .i_start (i_start),
    .i_data  (i_data),
    .o_TX    (o_TX),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  // frame: line level per bit without parity {stop, data[7:0], start}; par: expected even parity
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: line level for each bit period of a frame, bit 0 first on the wire.
  function automatic logic [NBITS-1:0] model_bits(input logic [7:0] d);
    logic [NBITS-1:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
    b[DW+1] = ^d;
`endif
    return b;
  endfunction

  function automatic logic [NBITS-1:0] table_bits(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.frame[8:0]};
`else
    return v.frame;
`endif
  endfunction

  // Checks every cycle from the one after accept through the o_done cycle.
  task automatic check_frame(input logic [NBITS-1:0] bits, input string name, input int poke_cycle);
    int fails_before;
    fails_before = total_cnt - pass_cnt;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      @(negedge i_clock);
      if (c < FRAME_LEN) begin
        chk({name, " tx"},   32'(o_TX),   32'(bits[c/CPB]));
        chk({name, " busy"}, 32'(o_busy), 32'd1);
        chk({name, " done"}, 32'(o_done), 32'd0);
      end else begin
        chk({name, " tx_end"},   32'(o_TX),   32'd1);
        chk({name, " busy_end"}, 32'(o_busy), 32'd0);
        chk({name, " done_end"}, 32'(o_done), 32'd1);
      end
      if (c == poke_cycle) begin
        i_start = 1'b1;
        i_data  = 8'($urandom);
      end else if (c == poke_cycle + 1) begin
        i_start = 1'b0;
      end
    end
    $display("frame %s bits=%b errors=%0d", name, bits, (total_cnt - pass_cnt) - fails_before);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge i_clock);
    i_start = 1'b1;
    i_data  = d;
    @(posedge i_clock);
    #1;
    i_start = 1'b0;
    i_data  = 8'($urandom);
  endtask

  initial begin
    vecs[0] = '{8'h55, 10'h2AA, 1'b0};
    vecs[1] = '{8'h07, 10'h20E, 1'b1};
    vecs[2] = '{8'h03, 10'h206, 1'b0};
    vecs[3] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[4] = '{8'h00, 10'h200, 1'b0};
    vecs[5] = '{8'hA5, 10'h34A, 1'b0};
    vecs[6] = '{8'h3C, 10'h278, 1'b0};
    vecs[7] = '{8'h80, 10'h300, 1'b1};

    // Reset state
    repeat (3) @(negedge i_clock);
    chk("reset tx",   32'(o_TX),   32'd1);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);

    // Accept on the first rising edge after release
    @(negedge i_clock);
    i_resetL = 1'b1;
    i_start  = 1'b1;
    i_data   = vecs[0].data;
    @(posedge i_clock);
    #1;
    i_start = 1'b0;
    i_data  = 8'($urandom);
    check_frame(table_bits(vecs[0]), "vec0", -10);

    for (int k = 1; k < 8; k++) begin
      send(vecs[k].data);
      check_frame(table_bits(vecs[k]), $sformatf("vec%0d", k), -10);
    end

    // Back-to-back frames with i_start held high
    @(negedge i_clock);
    i_start = 1'b1;
    i_data  = 8'hA5;
    @(posedge i_clock);
    #1 i_data = 8'h3C;
    check_frame(model_bits(8'hA5), "b2b_a5", -10);
    @(posedge i_clock);
    #1 i_data = 8'hFF;
    check_frame(model_bits(8'h3C), "b2b_3c", -10);
    @(posedge i_clock);
    #1 i_start = 1'b0;
    check_frame(model_bits(8'hFF), "b2b_ff", -10);

    // i_start with new data mid-frame is ignored
    send(8'h55);
    check_frame(model_bits(8'h55), "ignored_start", 10);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clock);
      chk("single done", 32'(o_done), 32'd0);
      chk("idle busy",   32'(o_busy), 32'd0);
    end

    // Randomized frames against the reference model
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send(d);
      check_frame(model_bits(d), $sformatf("rand%0d_%02h", k, d), -10);
    end

    // Reset at cycle 17 of a 0x00 frame
    begin
      logic [NBITS-1:0] bits;
      bits = model_bits(8'h00);
      send(8'h00);
      for (int c = 0; c <= 17; c++) begin
        @(negedge i_clock);
        chk("pre_reset tx", 32'(o_TX), 32'(bits[c/CPB]));
      end
      #1 i_resetL = 1'b0;
      #1;
      chk("async reset tx",   32'(o_TX),   32'd1);
      chk("async reset busy", 32'(o_busy), 32'd0);
      for (int c = 0; c < FRAME_LEN; c++) begin
        @(negedge i_clock);
        chk("in_reset done", 32'(o_done), 32'd0);
        chk("in_reset tx",   32'(o_TX),   32'd1);
      end
      $display("reset mid-frame at cycle 17 of 0x00 frame");
      i_resetL = 1'b1;
      i_start  = 1'b1;
      i_data   = 8'hC3;
      @(posedge i_clock);
      #1;
      i_start = 1'b0;
      i_data  = 8'($urandom);
      check_frame(model_bits(8'hC3), "after_reset", -10);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
